// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle RV32I controller.
// Holds the FSM state enum, the datapath select/op encodings, the opcode
// constants, the control-word struct and the immediate-format helper.
package mc_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
    MEM_WR, BRANCH, JAL, JALR_ADR, JALR_PC, LUI
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110
  } aluop_t;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_S = 3'b001,
    EXT_B = 3'b010,
    EXT_U = 3'b011,
    EXT_J = 3'b100
  } ext_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MDR    = 2'b01,
    RES_ALU    = 2'b10,
    RES_IMM    = 2'b11
  } res_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_t;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // Full control word driven to the datapath in one cycle
  typedef struct packed {
    logic   pcwrite;
    logic   adrsrc;
    logic   irwrite;
    logic   memwrite;
    logic   regwrite;
    res_t   resultsrc;
    srca_t  alusrca;
    srcb_t  alusrcb;
    aluop_t aluop;
    ext_t   extend_func;
    logic   illegal;
  } ctrl_t;

  // Immediate format implied by the opcode; formats without an immediate use I
  function automatic ext_t ext_of(input logic [OP_W-1:0] op);
    ext_t f;
    case (op)
      OP_STORE:  f = EXT_S;
      OP_BRANCH: f = EXT_B;
      OP_LUI:    f = EXT_U;
      OP_JAL:    f = EXT_J;
      default:   f = EXT_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps func3 (and func7[5] for R-type) to the ALU operation and
// flags func3 values this core does not implement (shifts, unsigned branches).
// Ports: i_op opcode, i_func3, i_func7_5 -> o_aluop, o_illegal_func.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [F3_W-1:0] i_func3,
  input  logic            i_func7_5,
  output aluop_t          o_aluop,
  output logic            o_illegal_func
);

  logic w_is_r;

  always_comb begin
    o_aluop        = ALU_ADD;
    o_illegal_func = 1'b0;
    w_is_r         = (i_op == OP_R);
    if (i_op == OP_R || i_op == OP_I) begin
      case (i_func3)
        3'b000:  o_aluop = (w_is_r && i_func7_5) ? ALU_SUB : ALU_ADD;
        3'b111:  o_aluop = ALU_AND;
        3'b110:  o_aluop = ALU_OR;
        3'b100:  o_aluop = ALU_XOR;
        3'b010:  o_aluop = ALU_SLT;
        3'b011:  o_aluop = ALU_SLTU;
        default: o_illegal_func = 1'b1;
      endcase
    end else if (i_op == OP_BRANCH) begin
      // Only beq/bne/blt/bge are supported
      case (i_func3)
        3'b000, 3'b001, 3'b100, 3'b101: o_illegal_func = 1'b0;
        default:                        o_illegal_func = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared-ALU multi-cycle
// RV32I datapath. Inputs: clk, rst (sync, active-high), op/func3/func7 from
// the IR, zero/neg ALU flags. Outputs: PC/IR/memory/regfile write enables,
// mux selects, ALU op, immediate format and an illegal-instruction pulse.
// Outputs decode the current state and the IR fields; the only input-to-
// output path from the ALU flags is pcwrite in BRANCH.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [F3_W-1:0] func3,
  input  logic [F7_W-1:0] func7,
  input  logic            zero,
  input  logic            neg,
  output logic            pcwrite,
  output logic            adrsrc,
  output logic            irwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic [1:0]      resultsrc,
  output logic [1:0]      alusrca,
  output logic [1:0]      alusrcb,
  output logic [2:0]      aluop,
  output logic [2:0]      extend_func,
  output logic            illegal
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  aluop_t w_dec_aluop;
  logic   w_illegal_func;
  logic   w_taken;
  logic   w_unused;

  // Only func7[5] distinguishes add/sub
  assign w_unused = ^{func7[6], func7[4:0]};

  alu_decoder u_alu_decoder (
    .i_op           (op),
    .i_func3        (func3),
    .i_func7_5      (func7[5]),
    .o_aluop        (w_dec_aluop),
    .o_illegal_func (w_illegal_func)
  );

  // Branch condition from the RS1-RS2 subtraction flags
  always_comb begin
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg;
      default: w_taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next;
  end

  // Next-state and control decode
  always_comb begin
    w_next = FETCH;
    w_ctrl = '0;
    case (r_state)
      FETCH: begin
        w_ctrl.irwrite   = 1'b1;
        w_ctrl.pcwrite   = 1'b1;
        w_ctrl.alusrca   = SRCA_PC;
        w_ctrl.alusrcb   = SRCB_FOUR;
        w_ctrl.aluop     = ALU_ADD;
        w_ctrl.resultsrc = RES_ALU;
        w_next           = DECODE;
      end
      DECODE: begin
        // ALUOut <= OldPC + imm, the target for branches and jal
        w_ctrl.alusrca     = SRCA_OLDPC;
        w_ctrl.alusrcb     = SRCB_IMM;
        w_ctrl.aluop       = ALU_ADD;
        w_ctrl.extend_func = ext_of(op);
        case (op)
          OP_R:             w_next = EXEC_R;
          OP_I:             w_next = EXEC_I;
          OP_LOAD, OP_STORE: w_next = MEM_ADR;
          OP_BRANCH:        w_next = BRANCH;
          OP_JAL:           w_next = JAL;
          OP_JALR:          w_next = JALR_ADR;
          OP_LUI:           w_next = LUI;
          default:          w_next = FETCH;
        endcase
        if (w_next == FETCH || w_illegal_func) begin
          w_ctrl.illegal = 1'b1;
          w_next         = FETCH;
        end
      end
      EXEC_R: begin
        w_ctrl.alusrca = SRCA_RS1;
        w_ctrl.alusrcb = SRCB_RS2;
        w_ctrl.aluop   = w_dec_aluop;
        w_next         = ALU_WB;
      end
      EXEC_I: begin
        w_ctrl.alusrca = SRCA_RS1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = w_dec_aluop;
        w_next         = ALU_WB;
      end
      ALU_WB: begin
        w_ctrl.resultsrc = RES_ALUOUT;
        w_ctrl.regwrite  = 1'b1;
        w_next           = FETCH;
      end
      MEM_ADR: begin
        w_ctrl.alusrca = SRCA_RS1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALU_ADD;
        w_next         = (op == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        w_ctrl.adrsrc = 1'b1;
        w_next        = MEM_WB;
      end
      MEM_WB: begin
        w_ctrl.resultsrc = RES_MDR;
        w_ctrl.regwrite  = 1'b1;
        w_next           = FETCH;
      end
      MEM_WR: begin
        w_ctrl.adrsrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_next          = FETCH;
      end
      BRANCH: begin
        // Signed overflow of the subtraction is deliberately not considered
        w_ctrl.alusrca   = SRCA_RS1;
        w_ctrl.alusrcb   = SRCB_RS2;
        w_ctrl.aluop     = ALU_SUB;
        w_ctrl.resultsrc = RES_ALUOUT;
        w_ctrl.pcwrite   = w_taken;
        w_next           = FETCH;
      end
      JAL: begin
        // PC <= target held in ALUOut while the ALU forms OldPC+4 for rd
        w_ctrl.alusrca   = SRCA_OLDPC;
        w_ctrl.alusrcb   = SRCB_FOUR;
        w_ctrl.aluop     = ALU_ADD;
        w_ctrl.resultsrc = RES_ALUOUT;
        w_ctrl.pcwrite   = 1'b1;
        w_next           = ALU_WB;
      end
      JALR_ADR: begin
        w_ctrl.alusrca = SRCA_RS1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALU_ADD;
        w_next         = JALR_PC;
      end
      JALR_PC: begin
        w_ctrl.alusrca   = SRCA_OLDPC;
        w_ctrl.alusrcb   = SRCB_FOUR;
        w_ctrl.aluop     = ALU_ADD;
        w_ctrl.resultsrc = RES_ALUOUT;
        w_ctrl.pcwrite   = 1'b1;
        w_next           = ALU_WB;
      end
      LUI: begin
        w_ctrl.extend_func = EXT_U;
        w_ctrl.resultsrc   = RES_IMM;
        w_ctrl.regwrite    = 1'b1;
        w_next             = FETCH;
      end
      default: w_next = FETCH;
    endcase
    // Reset presents FETCH selects with every enable and the pulse held low
    if (rst) begin
      w_ctrl           = '0;
      w_ctrl.alusrcb   = SRCB_FOUR;
      w_ctrl.resultsrc = RES_ALU;
    end
  end

  assign pcwrite     = w_ctrl.pcwrite;
  assign adrsrc      = w_ctrl.adrsrc;
  assign irwrite     = w_ctrl.irwrite;
  assign memwrite    = w_ctrl.memwrite;
  assign regwrite    = w_ctrl.regwrite;
  assign resultsrc   = w_ctrl.resultsrc;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign aluop       = w_ctrl.aluop;
  assign extend_func = w_ctrl.extend_func;
  assign illegal     = w_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus side expands each
// instruction into its expected per-cycle control words and queues them; a
// negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       neg;
  logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] aluop, extend_func;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .zero(zero), .neg(neg), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .extend_func(extend_func), .illegal(illegal)
  );

  typedef struct packed {
    logic       pc, adr, ir, mem, reg_we;
    logic [1:0] res, sa, sb;
    logic [2:0] alu, ext;
    logic       ill;
  } vec_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111;

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  act;
  vec_t  m_exp;
  string m_tag;

  assign act = {pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
                alusrca, alusrcb, aluop, extend_func, illegal};

  function automatic vec_t mk(input logic pc, adr, ir, mem, rw,
                              input logic [1:0] res, sa, sb,
                              input logic [2:0] alu, ext, input logic ill);
    return {pc, adr, ir, mem, rw, res, sa, sb, alu, ext, ill};
  endfunction

  // Reference: what the ISA and the datapath need, cycle by cycle
  function automatic bit supported_alu_f3(input logic [2:0] f);
    return !(f == 3'd1 || f == 3'd5);
  endfunction

  function automatic logic [2:0] alu_of(input bit is_r, input logic [2:0] f, input logic f7b5);
    case (f)
      3'd0: return (is_r && f7b5) ? 3'd1 : 3'd0;
      3'd7: return 3'd2;
      3'd6: return 3'd3;
      3'd4: return 3'd4;
      3'd2: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic step(input vec_t e, input string tag, input logic r,
                      input logic [6:0] o, input logic [2:0] f,
                      input logic f7b5, input logic z, input logic n);
    @(posedge clk); #1;
    rst = r; op = o; func3 = f;
    func7 = {1'($urandom), f7b5, 5'($urandom)};
    zero = z; neg = n;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(mk(0,0,0,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0), "reset", 1'b1,
           7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f, input logic f7b5,
                       input logic z, input logic n, input int max_cyc, input string name);
    vec_t s[$];
    vec_t wb;
    bit   ok;
    logic taken;
    logic [2:0] ext;
    wb  = mk(0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
    ext = (o == SW) ? 3'd1 : (o == BR) ? 3'd2 : (o == LU) ? 3'd3 : (o == JL) ? 3'd4 : 3'd0;
    case (o)
      R, I:   ok = supported_alu_f3(f);
      BR:     ok = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5);
      LW, SW, JL, JR, LU: ok = 1;
      default: ok = 0;
    endcase
    taken = (f == 3'd0) ? z : (f == 3'd1) ? !z : (f == 3'd4) ? n : !n;
    s.push_back(mk(1,0,1,0,0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0));
    s.push_back(mk(0,0,0,0,0, 2'd0, 2'd1, 2'd1, 3'd0, ext, !ok));
    if (ok) begin
      case (o)
        R: begin s.push_back(mk(0,0,0,0,0, 2'd0, 2'd2, 2'd0, alu_of(1, f, f7b5), 3'd0, 0)); s.push_back(wb); end
        I: begin s.push_back(mk(0,0,0,0,0, 2'd0, 2'd2, 2'd1, alu_of(0, f, f7b5), 3'd0, 0)); s.push_back(wb); end
        LW: begin
          s.push_back(mk(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
          s.push_back(mk(0,1,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
          s.push_back(mk(0,0,0,0,1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0));
        end
        SW: begin
          s.push_back(mk(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
          s.push_back(mk(0,1,0,1,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
        end
        BR: s.push_back(mk(taken,0,0,0,0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0, 0));
        JL: begin s.push_back(mk(1,0,0,0,0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0)); s.push_back(wb); end
        JR: begin
          s.push_back(mk(0,0,0,0,0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0));
          s.push_back(mk(1,0,0,0,0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0));
          s.push_back(wb);
        end
        default: s.push_back(mk(0,0,0,0,1, 2'd3, 2'd0, 2'd0, 3'd0, 3'd3, 0));
      endcase
    end
    for (int i = 0; i < s.size() && i < max_cyc; i++)
      step(s[i], $sformatf("%s op=%b f3=%0d c%0d", name, o, f, i), 1'b0, o, f, f7b5,
           (i == 2) ? z : 1'($urandom), (i == 2) ? n : 1'($urandom));
  endtask

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      n_cmp++;
      if (act !== m_exp) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", m_tag, act, m_exp);
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    ops[0] = R; ops[1] = I; ops[2] = LW; ops[3] = SW;
    ops[4] = BR; ops[5] = JL; ops[6] = JR; ops[7] = LU;
    rst = 1'b1; op = '0; func3 = '0; func7 = '0; zero = 1'b0; neg = 1'b0;
    do_reset(2);
    issue(R,  3'd0, 1'b0, 0, 0, 99, "add");
    issue(R,  3'd0, 1'b1, 0, 0, 99, "sub");
    issue(LW, 3'd2, 1'b0, 0, 0, 99, "lw");
    issue(SW, 3'd2, 1'b0, 0, 0, 99, "sw");
    issue(BR, 3'd0, 1'b0, 1, 0, 99, "beq_z1");
    issue(BR, 3'd0, 1'b0, 0, 0, 99, "beq_z0");
    issue(BR, 3'd4, 1'b0, 0, 1, 99, "blt_n1");
    issue(JL, 3'd0, 1'b0, 0, 0, 99, "jal");
    issue(JR, 3'd0, 1'b0, 0, 0, 99, "jalr");
    issue(LU, 3'd5, 1'b0, 0, 0, 99, "lui");
    issue(7'd0, 3'd0, 1'b0, 0, 0, 99, "bad_op");
    issue(I,  3'd1, 1'b0, 0, 0, 99, "bad_f3");
    issue(BR, 3'd6, 1'b0, 0, 0, 99, "bad_br");
    // Abort an R-type while it sits in EXEC_R
    issue(R,  3'd7, 1'b0, 0, 0, 2, "r_abort");
    do_reset(3);
    issue(I,  3'd0, 1'b1, 0, 0, 99, "after_rst");
    for (int k = 0; k < 300; k++) begin
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      issue(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 99, "rand");
      if ($urandom_range(0, 40) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
